return_address_stack: RTL and testbench
=======================================

// Module: return_address_stack
// PURPOSE
//  Circular return-address stack (RAS) that serves the decode stage's push/pop requests for
//  jal/jalr call/return prediction. Top-of-stack (TOS) is read combinationally so decode can
//  redirect pc_wdata in the same cycle it pops. A one-entry checkpoint, plus a flush, lets the
//  pipeline repair the stack after a branch mispredict.
// PARAMETERS
//  DEPTH  8   number of entries; power of two, >= 2
//  WIDTH  32  return-address width in bits
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              reset; asynchronous, active-low
//  push         in   1              push addr_in this cycle
//  pop          in   1              pop TOS this cycle
//  addr_in      in   WIDTH          address to push (pc + 4 of the call)
//  addr_out     out  WIDTH          current TOS; combinational; 0 when empty
//  empty        out  1              count == 0
//  full         out  1              count == DEPTH
//  count        out  $clog2(DEPTH)+1  number of valid entries
//  flush        in   1              synchronous clear to empty
//  ckpt_save    in   1              snapshot {tos_ptr, count, mem[tos_ptr]}
//  ckpt_restore in   1              restore state from the snapshot
// BEHAVIOUR
//  - Reset (rst low, asynchronous):
//    - tos_ptr, count, all entries and the snapshot clear to 0.
//    - Outputs: addr_out = 0, empty = 1, full = 0, count = 0.
//  - State: mem[DEPTH], tos_ptr (index of TOS, arithmetic mod DEPTH), count (saturates at DEPTH).
//  - addr_out = empty ? 0 : mem[tos_ptr]. There is no read latency.
//  - All updates happen at the clock edge. Priority per cycle: flush > ckpt_restore > push/pop.
//  - flush: count <= 0 and tos_ptr <= 0. Entries are not cleared.
//    push, pop and ckpt_restore are ignored that cycle.
//  - ckpt_restore: tos_ptr <= snap_ptr, count <= snap_cnt, mem[snap_ptr] <= snap_top.
//    push/pop are ignored that cycle.
//  - Push only:
//    - tos_ptr <= tos_ptr + 1 (wraps DEPTH-1 -> 0), then mem[new ptr] <= addr_in.
//    - count <= min(count + 1, DEPTH).
//    - When full, the oldest entry is silently overwritten and full stays 1.
//  - Pop only:
//    - If count > 0: tos_ptr <= tos_ptr - 1 (wraps 0 -> DEPTH-1) and count <= count - 1.
//    - If empty: no state change (underflow ignored).
//  - Push and pop together:
//    - Non-empty: mem[tos_ptr] <= addr_in; tos_ptr and count are unchanged
//      (replace-top, used by jalr with link). addr_out this cycle shows the old TOS.
//    - Empty: behaves as push only.
//  - ckpt_save: snap_ptr, snap_cnt and snap_top capture the PRE-update state of this cycle,
//    even if push/pop also occurs.
//    - If ckpt_restore is asserted in the same cycle, restore wins and the snapshot is unchanged.
//    - If flush is asserted in the same cycle, the snapshot still captures the pre-flush state.
//  - Idle (no request): all state is held.
//  - No handshake: every request is accepted in the cycle it is presented. The requester gates
//    requests on stall and mispredict; this block does not check them.
// TESTING
//  - Reset: after rst deassert -> empty = 1, full = 0, count = 0, addr_out = 0.
//    Asserting rst mid-sequence returns the block to these values immediately.
//  - LIFO order: push 0x100, 0x200, 0x300; pop x3.
//    -> addr_out reads 0x300, 0x200, 0x100 before each pop; then empty = 1 and addr_out = 0.
//  - Overflow wrap (DEPTH = 8): push 0x10..0x90 (9 pushes).
//    -> full = 1, count = 8, TOS = 0x90; 8 pops return 0x90..0x20; 0x10 is lost.
//  - Underflow: pop while empty -> count stays 0 and tos_ptr unchanged.
//    A following push of 0x40 gives addr_out = 0x40.
//  - Replace-top: stack {0x100, 0x200}; push+pop with addr_in = 0x500.
//    -> count = 2 and addr_out = 0x500; one pop then gives 0x100.
//    - Push+pop while empty with 0x600 -> count = 1, addr_out = 0x600.
//  - Checkpoint:
//    - Stack {0xA0, 0xB0}; ckpt_save; pop; push 0xC0; push 0xD0; ckpt_restore.
//      -> count = 2, addr_out = 0xB0.
//    - flush together with ckpt_restore -> empty = 1.

Source files
------------

// File: rtl/return_address_stack_if.sv
// return_address_stack_if: decode-side request/response bundle for the return-address stack
interface return_address_stack_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] addr_out;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             flush;
  logic             ckpt_save;
  logic             ckpt_restore;
  modport master (
    output push, pop, addr_in, flush, ckpt_save, ckpt_restore,
    input  addr_out, empty, full, count
  );
  modport slave (
    input  push, pop, addr_in, flush, ckpt_save, ckpt_restore,
    output addr_out, empty, full, count
  );
endinterface

// File: rtl/return_address_stack.sv
// return_address_stack: circular call/return predictor stack with one-entry checkpoint and flush
module return_address_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  return_address_stack_if.slave ras
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tos_ptr;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    snap_ptr;
  logic [CW-1:0]    snap_cnt;
  logic [WIDTH-1:0] snap_top;
  logic [PW-1:0]    nxt_ptr;
  logic [CW-1:0]    nxt_cnt;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             save_en;
  logic             is_empty;
  logic             is_full;
  // Status flags and combinational top-of-stack read for same-cycle redirect
  always_comb begin
    is_empty     = cnt == '0;
    is_full      = cnt == CW'(DEPTH);
    ras.empty    = is_empty;
    ras.full     = is_full;
    ras.count    = cnt;
    ras.addr_out = is_empty ? '0 : mem[tos_ptr];
  end
  // Next pointer/count and the single memory write, in flush > restore > push/pop priority
  always_comb begin
    nxt_ptr = tos_ptr;
    nxt_cnt = cnt;
    wr_en   = 1'b0;
    wr_idx  = tos_ptr;
    wr_data = ras.addr_in;
    save_en = ras.ckpt_save && !ras.ckpt_restore;
    if (ras.flush) begin
      nxt_ptr = '0;
      nxt_cnt = '0;
    end else if (ras.ckpt_restore) begin
      nxt_ptr = snap_ptr;
      nxt_cnt = snap_cnt;
      wr_en   = 1'b1;
      wr_idx  = snap_ptr;
      wr_data = snap_top;
    end else if (ras.push && ras.pop && !is_empty) begin
      wr_en   = 1'b1;
    end else if (ras.push) begin
      nxt_ptr = tos_ptr + PW'(1);
      nxt_cnt = cnt + CW'(!is_full);
      wr_en   = 1'b1;
      wr_idx  = tos_ptr + PW'(1);
    end else if (ras.pop && !is_empty) begin
      nxt_ptr = tos_ptr - PW'(1);
      nxt_cnt = cnt - CW'(1);
    end
  end
  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_ptr <= '0;
      cnt     <= '0;
    end else begin
      tos_ptr <= nxt_ptr;
      cnt     <= nxt_cnt;
    end
  end
  // Entry storage; a full push lands on the oldest slot, overwriting it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end
  // Checkpoint captures the pre-update state; a simultaneous restore keeps the old snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_ptr <= '0;
      snap_cnt <= '0;
      snap_top <= '0;
    end else if (save_en) begin
      snap_ptr <= tos_ptr;
      snap_cnt <= cnt;
      snap_top <= mem[tos_ptr];
    end
  end
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: scoreboard bench with a circular-array reference model
module tb_return_address_stack;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  return_address_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) ras();
  return_address_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .ras(ras));
  obs_t expq[$];
  obs_t e;
  int compared = 0;
  int mismatched = 0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  int m_ptr, m_cnt, s_ptr, s_cnt;
  logic [WIDTH-1:0] s_top;
  function automatic obs_t model_out();
    obs_t r;
    r.addr  = (m_cnt == 0) ? '0 : m_mem[m_ptr];
    r.cnt   = CW'(m_cnt);
    r.empty = m_cnt == 0;
    r.full  = m_cnt == DEPTH;
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0; m_cnt = 0; s_ptr = 0; s_cnt = 0; s_top = '0;
  endtask
  task automatic model_step(input bit p, input bit o, input logic [WIDTH-1:0] a,
                            input bit f, input bit s, input bit r);
    if (s && !r) begin s_ptr = m_ptr; s_cnt = m_cnt; s_top = m_mem[m_ptr]; end
    if (f) begin
      m_ptr = 0; m_cnt = 0;
    end else if (r) begin
      m_ptr = s_ptr; m_cnt = s_cnt; m_mem[s_ptr] = s_top;
    end else if (p && o && m_cnt > 0) begin
      m_mem[m_ptr] = a;
    end else if (p) begin
      m_ptr = (m_ptr + 1) % DEPTH;
      m_mem[m_ptr] = a;
      if (m_cnt < DEPTH) m_cnt++;
    end else if (o && m_cnt > 0) begin
      m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
      m_cnt--;
    end
  endtask
  task automatic drive(input bit p, input bit o, input logic [WIDTH-1:0] a,
                       input bit f, input bit s, input bit r);
    ras.push = p; ras.pop = o; ras.addr_in = a;
    ras.flush = f; ras.ckpt_save = s; ras.ckpt_restore = r;
  endtask
  task automatic cycle(input bit p, input bit o, input logic [WIDTH-1:0] a,
                       input bit f, input bit s, input bit r);
    @(posedge clk);
    #1;
    expq.push_back(model_out());
    drive(p, o, a, f, s, r);
    model_step(p, o, a, f, s, r);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, '0, 0, 0, 0);
    model_reset();
    expq.push_back(model_out());
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      compared++;
      if (ras.addr_out !== e.addr) begin
        mismatched++;
        $display("FAIL addr_out t=%0t got %h want %h", $time, ras.addr_out, e.addr);
      end
      compared++;
      if (ras.count !== e.cnt) begin
        mismatched++;
        $display("FAIL count t=%0t got %0d want %0d", $time, ras.count, e.cnt);
      end
      compared++;
      if (ras.empty !== e.empty) begin
        mismatched++;
        $display("FAIL empty t=%0t got %b want %b", $time, ras.empty, e.empty);
      end
      compared++;
      if (ras.full !== e.full) begin
        mismatched++;
        $display("FAIL full t=%0t got %b want %b", $time, ras.full, e.full);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int v;
    logic [WIDTH-1:0] a;
    drive(0, 0, '0, 0, 0, 0);
    model_reset();
    do_reset();
    idle(2);
    cycle(1, 0, 32'h100, 0, 0, 0);
    cycle(1, 0, 32'h200, 0, 0, 0);
    cycle(1, 0, 32'h300, 0, 0, 0);
    repeat (3) cycle(0, 1, '0, 0, 0, 0);
    idle(1);
    for (int i = 1; i <= 9; i++) cycle(1, 0, WIDTH'(i * 16), 0, 0, 0);
    repeat (8) cycle(0, 1, '0, 0, 0, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(1, 0, 32'h40, 0, 0, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(0, 0, '0, 1, 0, 0);
    cycle(1, 0, 32'h100, 0, 0, 0);
    cycle(1, 0, 32'h200, 0, 0, 0);
    cycle(1, 1, 32'h500, 0, 0, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(1, 1, 32'h600, 0, 0, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(1, 0, 32'hA0, 0, 0, 0);
    cycle(1, 0, 32'hB0, 0, 0, 0);
    cycle(0, 0, '0, 0, 1, 0);
    cycle(0, 1, '0, 0, 0, 0);
    cycle(1, 0, 32'hC0, 0, 0, 0);
    cycle(1, 0, 32'hD0, 0, 0, 0);
    cycle(0, 0, '0, 0, 0, 1);
    idle(1);
    cycle(0, 0, '0, 1, 0, 1);
    idle(1);
    cycle(1, 0, 32'hE0, 0, 1, 0);
    cycle(1, 1, 32'hF0, 1, 1, 0);
    cycle(0, 0, '0, 0, 0, 1);
    cycle(1, 0, 32'h111, 0, 1, 1);
    cycle(0, 0, '0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 1500; i++) begin
      v = $urandom_range(0, 99);
      a = $urandom & 32'hFFFF_FFFC;
      if (v < 30) cycle(1, 0, a, 0, $urandom_range(0, 9) == 0, 0);
      else if (v < 60) cycle(0, 1, a, 0, $urandom_range(0, 9) == 0, 0);
      else if (v < 70) cycle(1, 1, a, 0, 0, 0);
      else if (v < 73) cycle(0, 0, a, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else if (v < 83) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, 0, 1, 0);
      else if (v < 91) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, 0,
                             $urandom_range(0, 1) == 1, 1);
      else cycle(0, 0, a, 0, 0, 0);
      if (i == 700) do_reset();
    end
    idle(2);
    @(negedge clk);
    #1;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got %0d pending want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
